// File: rtl/bypass_table_arbiter_if.sv
// Requester and table-wrapper signal bundle for bypass_table_arbiter.
// The slave modport is the arbiter's view; master is the requester/wrapper side.
interface bypass_table_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
);
    logic              clear_req;
    logic              busy;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd0_valid;
    logic              rd0_ready;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd1_valid;
    logic              rd1_ready;
    logic [ADDR_W-1:0] rd1_addr;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_data;

    logic [ADDR_W-1:0] tbl_wr_addr;
    logic [DATA_W-1:0] tbl_wr_data;
    logic              tbl_wr_enable;
    logic [ADDR_W-1:0] tbl_rd_addr;
    logic              tbl_rd_enable;
    logic [DATA_W-1:0] tbl_rd_data;
    logic              tbl_rd_valid;

    modport slave (
        input  clear_req,
        input  wr_valid, wr_addr, wr_data,
        input  rd0_valid, rd0_addr, rd1_valid, rd1_addr,
        input  tbl_rd_data, tbl_rd_valid,
        output busy, wr_ready, rd0_ready, rd1_ready,
        output rsp0_valid, rsp1_valid, rsp_data,
        output tbl_wr_addr, tbl_wr_data, tbl_wr_enable,
        output tbl_rd_addr, tbl_rd_enable
    );

    modport master (
        output clear_req,
        output wr_valid, wr_addr, wr_data,
        output rd0_valid, rd0_addr, rd1_valid, rd1_addr,
        output tbl_rd_data, tbl_rd_valid,
        input  busy, wr_ready, rd0_ready, rd1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data,
        input  tbl_wr_addr, tbl_wr_data, tbl_wr_enable,
        input  tbl_rd_addr, tbl_rd_enable
    );
endinterface

// File: rtl/bypass_table_arbiter.sv
// Shares the single-port bypass-table wrapper between one writer and two read lanes,
// with a full-table clear sweep after reset and on request.
module bypass_table_arbiter #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 24,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter int                WR_BURST_MAX   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bypass_table_arbiter_if.slave  bus
);
    localparam int               BW        = $clog2(WR_BURST_MAX + 1);
    localparam logic [BW-1:0]    BURST_MAX = BW'(WR_BURST_MAX);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              rr_q;          // lane favoured when both lanes request
    logic [BW-1:0]     burst_q;
    logic              rd_lane_q;
    logic              rd_inflight_q;

    logic clearing;
    logic serving;
    logic rd_pending;
    logic wr_grant;
    logic rd_grant;
    logic rd_lane;
    logic rsp_fire;

    // NOTE: rst_n gates the combinational strobes so that enables and readys
    // drop the moment reset asserts, not at the next clock edge.
    always_comb begin
        clearing   = rst_n && (state_q == ST_CLEAR);
        serving    = rst_n && (state_q == ST_SERVE);
        rd_pending = bus.rd0_valid || bus.rd1_valid;
        wr_grant   = serving && bus.wr_valid && !(rd_pending && (burst_q == BURST_MAX));
        rd_grant   = serving && rd_pending && !wr_grant;
        if (bus.rd0_valid && bus.rd1_valid) begin
            rd_lane = rr_q;
        end else begin
            rd_lane = bus.rd1_valid;
        end
        rsp_fire   = rd_inflight_q && bus.tbl_rd_valid;
    end

    always_comb begin
        bus.busy       = busy_q;
        bus.wr_ready   = wr_grant;
        bus.rd0_ready  = rd_grant && !rd_lane;
        bus.rd1_ready  = rd_grant &&  rd_lane;

        bus.tbl_wr_enable = clearing || wr_grant;
        bus.tbl_wr_addr   = '0;
        bus.tbl_wr_data   = '0;
        if (clearing) begin
            bus.tbl_wr_addr = clr_cnt_q;
            bus.tbl_wr_data = CLEAR_VALUE;
        end else if (wr_grant) begin
            bus.tbl_wr_addr = bus.wr_addr;
            bus.tbl_wr_data = bus.wr_data;
        end

        bus.tbl_rd_enable = rd_grant;
        bus.tbl_rd_addr   = '0;
        if (rd_grant) begin
            bus.tbl_rd_addr = rd_lane ? bus.rd1_addr : bus.rd0_addr;
        end

        bus.rsp0_valid = rsp_fire && !rd_lane_q;
        bus.rsp1_valid = rsp_fire &&  rd_lane_q;
        bus.rsp_data   = rsp_fire ? bus.tbl_rd_data : '0;
    end

    // Sweep sequencer: the last address wraps clr_cnt_q back to zero on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            busy_q    <= CLEAR_ON_RESET;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == '1) begin
                        state_q <= ST_SERVE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (bus.clear_req) begin
                        state_q   <= ST_CLEAR;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_SERVE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Burst counter only limits writes while a read waits; idle cycles reset it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q          <= 1'b0;
            burst_q       <= '0;
            rd_lane_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            rd_inflight_q <= rd_grant;
            if (rd_grant) begin
                rd_lane_q <= rd_lane;
                rr_q      <= !rd_lane;
            end
            if (rd_grant || !rd_pending) begin
                burst_q <= '0;
            end else if (wr_grant && (burst_q != BURST_MAX)) begin
                burst_q <= burst_q + BW'(1);
            end
        end
    end

    a_enable_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.tbl_wr_enable && bus.tbl_rd_enable));

    a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({bus.wr_ready, bus.rd0_ready, bus.rd1_ready}));

endmodule

// File: tb/tb_bypass_table_arbiter.sv
// Directed bench for bypass_table_arbiter: a behavioural table wrapper, directed
// stimulus, and a scoreboard monitor that checks every lane response.
`timescale 1ns/1ps
module tb_bypass_table_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bypass_table_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bypass_table_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_VALUE(24'h000000),
        .CLEAR_ON_RESET(1'b1), .WR_BURST_MAX(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Table wrapper model: one-cycle read latency, not reset, preloaded with a junk pattern.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_init_q = 1'b0;
    initial begin
        bus.tbl_rd_valid = 1'b0;
        bus.tbl_rd_data  = '0;
    end
    always @(posedge clk) begin
        if (!mem_init_q) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 24'h5A5A5A;
            mem_init_q <= 1'b1;
        end else if (bus.tbl_wr_enable) begin
            mem[bus.tbl_wr_addr] <= bus.tbl_wr_data;
        end
        bus.tbl_rd_valid <= bus.tbl_rd_enable;
        if (bus.tbl_rd_enable) bus.tbl_rd_data <= mem[bus.tbl_rd_addr];
    end

    typedef struct packed {
        logic              lane;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.rsp0_valid || bus.rsp1_valid)) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_lane", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, e.lane ? 32'd2 : 32'd1);
                check("rsp_data", {8'd0, bus.rsp_data}, {8'd0, e.data});
                check("rsp_latency", cyc, e.cyc);
            end
        end
    end

    task automatic to_drive();
        @(posedge clk); #1;
    endtask

    // Holds a write request from the current drive point until granted.
    task automatic wr_req(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          output int waits);
        bit got;
        got = 1'b0; waits = 0;
        bus.wr_valid = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        while (!got && waits < 600) begin
            @(negedge clk);
            if (bus.wr_ready) got = 1'b1;
            else waits++;
            to_drive();
        end
        bus.wr_valid = 1'b0;
        check("wr_grant", {31'd0, got}, 32'd1);
    endtask

    task automatic rd_req(input bit lane, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] exp, output int waits);
        bit got;
        got = 1'b0; waits = 0;
        if (lane) begin bus.rd1_valid = 1'b1; bus.rd1_addr = addr; end
        else      begin bus.rd0_valid = 1'b1; bus.rd0_addr = addr; end
        while (!got && waits < 600) begin
            @(negedge clk);
            if (lane ? bus.rd1_ready : bus.rd0_ready) begin
                got = 1'b1;
                sb_q.push_back('{lane: lane, data: exp, cyc: cyc + 1});
            end else begin
                waits++;
            end
            to_drive();
        end
        if (lane) bus.rd1_valid = 1'b0;
        else      bus.rd0_valid = 1'b0;
        check("rd_grant", {31'd0, got}, 32'd1);
    endtask

    // Counts busy cycles from the next falling edge and checks the address walk.
    task automatic sweep_check(input string tag, input bit poke);
        int n, errs;
        n = 0; errs = 0;
        @(negedge clk);
        while (bus.busy && n < 400) begin
            if (bus.tbl_wr_enable !== 1'b1 || bus.tbl_wr_addr !== n[7:0] ||
                bus.tbl_wr_data !== 24'h0 || bus.wr_ready || bus.rd0_ready ||
                bus.rd1_ready || bus.tbl_rd_enable) errs++;
            if (poke && n == 100) bus.clear_req = 1'b1;
            if (poke && n == 101) bus.clear_req = 1'b0;
            n++;
            @(negedge clk);
        end
        check({tag, "_len"}, n, 32'd256);
        check({tag, "_errs"}, errs, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     {31'd0, bus.busy}, 32'd1);
        check({tag, "_readys"},   {29'd0, bus.wr_ready, bus.rd0_ready, bus.rd1_ready}, 32'd0);
        check({tag, "_rsp"},      {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
        check({tag, "_enables"},  {30'd0, bus.tbl_wr_enable, bus.tbl_rd_enable}, 32'd0);
        check({tag, "_wr_addr"},  {24'd0, bus.tbl_wr_addr}, 32'd0);
        check({tag, "_rsp_data"}, {8'd0, bus.rsp_data}, 32'd0);
    endtask

    logic [11:0] burst_pat;
    initial begin
        int w, n, widx;
        bit exp_lane;
        bus.clear_req = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd0_valid = 1'b0; bus.rd0_addr = '0;
        bus.rd1_valid = 1'b0; bus.rd1_addr = '0;

        // Power-up reset and automatic sweep.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        to_drive();
        rst_n = 1'b1;
        sweep_check("boot_sweep", 1'b0);
        to_drive();

        rd_req(1'b0, 8'h10, 24'h000000, w);
        rd_req(1'b1, 8'hFF, 24'h000000, w);

        // Read-after-write on the following cycle.
        wr_req(8'h42, 24'hABCDEF, w);
        check("raw_wr_no_wait", w, 32'd0);
        rd_req(1'b0, 8'h42, 24'hABCDEF, w);
        check("raw_rd0_no_wait", w, 32'd0);
        rd_req(1'b1, 8'h42, 24'hABCDEF, w);

        // Round-robin with both lanes requesting continuously.
        wr_req(8'h01, 24'h111111, w);
        wr_req(8'h02, 24'h222222, w);
        bus.rd0_valid = 1'b1; bus.rd0_addr = 8'h01;
        bus.rd1_valid = 1'b1; bus.rd1_addr = 8'h02;
        exp_lane = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_rd0_ready", {31'd0, bus.rd0_ready}, {31'd0, !exp_lane});
            check("rr_rd1_ready", {31'd0, bus.rd1_ready}, {31'd0, exp_lane});
            sb_q.push_back('{lane: exp_lane, data: exp_lane ? 24'h222222 : 24'h111111, cyc: cyc + 1});
            exp_lane = !exp_lane;
            to_drive();
        end
        bus.rd0_valid = 1'b0;

        // Write burst limited to four grants while lane 1 waits.
        burst_pat = 12'b1101_1110_1111;  // bit i = 1 -> write granted in cycle i
        widx = 0;
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h60; bus.wr_data = 24'h600000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("burst_wr_ready",  {31'd0, bus.wr_ready},  {31'd0, burst_pat[i]});
            check("burst_rd1_ready", {31'd0, bus.rd1_ready}, {31'd0, !burst_pat[i]});
            if (bus.wr_ready) widx++;
            if (bus.rd1_ready) sb_q.push_back('{lane: 1'b1, data: 24'h222222, cyc: cyc + 1});
            to_drive();
            bus.wr_addr = 8'h60 + widx[7:0];
            bus.wr_data = 24'h600000 + widx[23:0];
            if (widx >= 10) bus.wr_valid = 1'b0;
        end
        bus.wr_valid = 1'b0; bus.rd1_valid = 1'b0;
        rd_req(1'b0, 8'h65, 24'h600005, w);

        // Back-to-back writes with no read pending.
        n = 0;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_addr = 8'h70 + i[7:0];
            bus.wr_data = 24'h700000 + i[23:0];
            @(negedge clk);
            if (bus.wr_ready) n++;
            to_drive();
        end
        bus.wr_valid = 1'b0;
        check("b2b_writes", n, 32'd10);
        rd_req(1'b1, 8'h79, 24'h700009, w);

        // Clear request alongside a lane-0 read; a second read waits out the sweep.
        bus.rd0_valid = 1'b1; bus.rd0_addr = 8'h70; bus.clear_req = 1'b1;
        @(negedge clk);
        check("clr_cycle_rd0_ready", {31'd0, bus.rd0_ready}, 32'd1);
        check("clr_cycle_busy", {31'd0, bus.busy}, 32'd0);
        if (bus.rd0_ready) sb_q.push_back('{lane: 1'b0, data: 24'h700000, cyc: cyc + 1});
        to_drive();
        bus.clear_req = 1'b0; bus.rd0_addr = 8'h71;
        sweep_check("cmd_sweep", 1'b1);
        check("post_clr_rd0_ready", {31'd0, bus.rd0_ready}, 32'd1);
        if (bus.rd0_ready) sb_q.push_back('{lane: 1'b0, data: 24'h000000, cyc: cyc + 1});
        to_drive();
        bus.rd0_valid = 1'b0;

        // Reset while a read is in flight: the response must be dropped.
        bus.rd0_valid = 1'b1; bus.rd0_addr = 8'h72;
        @(negedge clk);
        check("inflight_rd0_ready", {31'd0, bus.rd0_ready}, 32'd1);
        to_drive();
        bus.rd0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("inflight_reset");
        to_drive();
        rst_n = 1'b1;
        sweep_check("inflight_sweep", 1'b0);
        to_drive();

        // Reset in the middle of a commanded sweep.
        bus.clear_req = 1'b1;
        to_drive();
        bus.clear_req = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(bus.busy && bus.tbl_wr_addr == 8'h80) && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("mid_sweep_reached", {31'd0, bus.tbl_wr_addr == 8'h80}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_sweep_reset");
        to_drive();
        rst_n = 1'b1;
        sweep_check("restart_sweep", 1'b0);
        to_drive();

        rd_req(1'b0, 8'h42, 24'h000000, w);
        rd_req(1'b1, 8'h79, 24'h000000, w);
        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
